// File: rtl/mmio_timer_responder_pkg.sv
// Shared register map and bit positions for the MMIO timer responder.
// Offsets are byte offsets within the 32-byte window; decode uses bits [4:2].
package mmio_timer_responder_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PRESCALE = 5'h04;
  localparam logic [4:0] OFF_COMPARE  = 5'h08;
  localparam logic [4:0] OFF_COUNT    = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_AUTO    = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned STATUS_MATCH = 0;

  // Word index of a byte address inside the register window.
  function automatic logic [2:0] reg_sel(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/mmio_timer_responder_prescaler.sv
// Prescaler for the MMIO timer: pulses tick once every presc+1 enabled clocks.
// The counter is held at zero while disabled and restarts on clr.
module timer_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  // tick depends only on the enabled count; a same-cycle clr restarts the next period
  assign tick = en && (pcnt == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!en || clr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer responder: address decode, register file, prescaled
// 32-bit up-counter with compare match, W1C status and level interrupt.
module mmio_timer_responder
  import mmio_timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic        memwrite,
  input  logic [31:0] memwritedata,
  output logic        hit,
  output logic [31:0] memreaddata,
  output logic        irq
);

  logic [2:0]         ctrl;
  logic [PRESC_W-1:0] presc;
  logic [31:0]        compare;
  logic [31:0]        count;
  logic               match;

  logic [2:0]  ctrl_n;
  logic [31:0] count_n;
  logic        match_n;
  logic        tick;

  logic [2:0] sel;
  logic       wr;
  logic       wr_ctrl, wr_presc, wr_compare, wr_count, wr_status;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^memaddr[1:0];

  assign hit = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign sel = reg_sel(memaddr);
  assign wr  = hit && memwrite;

  assign wr_ctrl    = wr && (sel == OFF_CTRL[4:2]);
  assign wr_presc   = wr && (sel == OFF_PRESCALE[4:2]);
  assign wr_compare = wr && (sel == OFF_COMPARE[4:2]);
  assign wr_count   = wr && (sel == OFF_COUNT[4:2]);
  assign wr_status  = wr && (sel == OFF_STATUS[4:2]);

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (ctrl[CTRL_EN]),
    .clr  (wr_ctrl),
    .presc(presc),
    .tick (tick)
  );

  // Tick effects are computed first, then CPU writes override them; a COUNT
  // write suppresses the whole tick (no increment, no match, no one-shot stop).
  always_comb begin
    ctrl_n  = ctrl;
    count_n = count;
    match_n = match && !(wr_status && memwritedata[STATUS_MATCH]);
    if (tick && !wr_count) begin
      if (count == compare) begin
        match_n = 1'b1;
        if (ctrl[CTRL_AUTO]) begin
          count_n = '0;
        end else begin
          ctrl_n[CTRL_EN] = 1'b0;
        end
      end else begin
        count_n = count + 32'd1;
      end
    end
    if (wr_ctrl) begin
      ctrl_n = memwritedata[2:0];
    end
    if (wr_count) begin
      count_n = memwritedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl    <= '0;
      presc   <= '0;
      compare <= '0;
      count   <= '0;
      match   <= 1'b0;
    end else begin
      ctrl    <= ctrl_n;
      count   <= count_n;
      match   <= match_n;
      if (wr_presc) begin
        presc <= memwritedata[PRESC_W-1:0];
      end
      if (wr_compare) begin
        compare <= memwritedata;
      end
    end
  end

  assign irq = match && ctrl[CTRL_IE];

  always_comb begin
    memreaddata = '0;
    if (hit) begin
      case (sel)
        OFF_CTRL[4:2]:     memreaddata = {29'd0, ctrl};
        OFF_PRESCALE[4:2]: memreaddata = 32'(presc);
        OFF_COMPARE[4:2]:  memreaddata = compare;
        OFF_COUNT[4:2]:    memreaddata = count;
        OFF_STATUS[4:2]:   memreaddata = {31'd0, match};
        default:           memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Bench for mmio_timer_responder: directed scenarios with literal expectations
// plus randomized bus traffic checked every cycle against a register-level model.
module tb_mmio_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memaddr = 32'h0;
  logic        memwrite = 1'b0;
  logic [31:0] memwritedata = 32'h0;
  logic        hit;
  logic [31:0] memreaddata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mmio_timer_responder #(
    .BASE_ADDR(BASE),
    .PRESC_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memaddr     (memaddr),
    .memwrite    (memwrite),
    .memwritedata(memwritedata),
    .hit         (hit),
    .memreaddata (memreaddata),
    .irq         (irq)
  );

  // Register-level model of the peripheral
  logic        m_en = 0, m_auto = 0, m_ie = 0, m_match = 0;
  logic [15:0] m_presc = 0, m_pcnt = 0;
  logic [31:0] m_cmp = 0, m_cnt = 0;

  function automatic logic model_hit(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!model_hit(a)) return 32'h0;
    case (a[4:2])
      3'd0:    return {29'd0, m_ie, m_auto, m_en};
      3'd1:    return {16'd0, m_presc};
      3'd2:    return m_cmp;
      3'd3:    return m_cnt;
      3'd4:    return {31'd0, m_match};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model_update
    logic        w, tk;
    logic [2:0]  s;
    logic [31:0] d, cnt;
    logic [15:0] pc;
    logic        en, mt;
    if (reset) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_match = 0;
      m_presc = 0; m_pcnt = 0; m_cmp = 0; m_cnt = 0;
    end else begin
      w  = memwrite && model_hit(memaddr);
      s  = memaddr[4:2];
      d  = memwritedata;
      tk = m_en && (m_pcnt == m_presc);
      pc = (!m_en || tk || (w && s == 3'd0)) ? 16'd0 : m_pcnt + 16'd1;
      cnt = m_cnt;
      en  = m_en;
      mt  = m_match;
      if (w && s == 3'd4 && d[0]) mt = 0;
      if (tk && !(w && s == 3'd3)) begin
        if (m_cnt == m_cmp) begin
          mt = 1;
          if (m_auto) cnt = 0;
          else en = 0;
        end else begin
          cnt = m_cnt + 32'd1;
        end
      end
      if (w && s == 3'd3) cnt = d;
      m_pcnt  = pc;
      m_cnt   = cnt;
      m_match = mt;
      m_en    = en;
      if (w && s == 3'd0) begin
        m_en = d[0]; m_auto = d[1]; m_ie = d[2];
      end
      if (w && s == 3'd1) m_presc = d[15:0];
      if (w && s == 3'd2) m_cmp = d;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_hit", {31'd0, hit}, {31'd0, model_hit(memaddr)});
    check("model_rdata", memreaddata, model_read(memaddr));
    check("model_irq", {31'd0, irq}, {31'd0, m_match & m_ie});
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    @(posedge clk);
    #1;
    memaddr = a;
    memwrite = we;
    memwritedata = d;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    drive(BASE + 32'(off), 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(BASE + 32'h0C, 1'b0, 32'h0);
  endtask

  task automatic rd_check(input logic [4:0] off, input logic [31:0] exp, input string name);
    drive(BASE + 32'(off), 1'b0, 32'h0);
    @(negedge clk);
    check(name, memreaddata, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  w;
    logic        we;

    // Reset behaviour
    reset = 1'b1;
    memaddr = BASE;
    repeat (2) @(negedge clk);
    check("reset_ctrl", memreaddata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    wr(5'h0C, 32'd5);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'd1);
    idle(3);
    @(posedge clk);
    #1 memaddr = BASE + 32'h0C;
    #1 check("pre_reset_count", memreaddata, 32'd8);
    #1 reset = 1'b1;
    #1 check("async_reset_count", memreaddata, 32'h0);
    check("async_reset_irq", {31'd0, irq}, 32'h0);
    memaddr = BASE;
    #1 check("async_reset_ctrl", memreaddata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // One-shot
    wr(5'h04, 32'd0);
    wr(5'h08, 32'd2);
    wr(5'h00, 32'd1);
    idle(8);
    rd_check(5'h0C, 32'd2, "oneshot_count");
    check("oneshot_irq", {31'd0, irq}, 32'h0);
    rd_check(5'h00, 32'd0, "oneshot_ctrl");
    rd_check(5'h10, 32'd1, "oneshot_status");
    wr(5'h10, 32'd1);

    // Auto-reload with prescale 3
    wr(5'h04, 32'd3);
    wr(5'h08, 32'd10);
    wr(5'h0C, 32'd0);
    wr(5'h00, 32'd7);
    idle(40);
    rd_check(5'h0C, 32'd10, "auto_count10");
    idle(2);
    rd_check(5'h10, 32'd0, "auto_status_before");
    check("auto_irq_before", {31'd0, irq}, 32'h0);
    rd_check(5'h0C, 32'd0, "auto_reload");
    rd_check(5'h10, 32'd1, "auto_status_after");
    check("auto_irq_after", {31'd0, irq}, 32'h1);
    wr(5'h00, 32'd0);
    wr(5'h10, 32'd1);
    rd_check(5'h10, 32'd0, "auto_cleared");

    // Wrap
    wr(5'h0C, 32'hFFFF_FFFE);
    wr(5'h08, 32'd3);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'd1);
    idle(1);
    rd_check(5'h0C, 32'hFFFF_FFFF, "wrap_ff");
    rd_check(5'h0C, 32'd0, "wrap_0");
    rd_check(5'h0C, 32'd1, "wrap_1");
    rd_check(5'h10, 32'd0, "wrap_no_match");
    idle(5);
    rd_check(5'h0C, 32'd3, "wrap_hold3");
    rd_check(5'h10, 32'd1, "wrap_match");
    wr(5'h10, 32'd1);

    // Collisions
    wr(5'h08, 32'd1000);
    wr(5'h0C, 32'd0);
    wr(5'h00, 32'd3);
    idle(2);
    wr(5'h0C, 32'd100);
    rd_check(5'h0C, 32'd100, "count_write_wins");
    wr(5'h00, 32'd0);
    wr(5'h0C, 32'd98);
    wr(5'h08, 32'd100);
    wr(5'h10, 32'd1);
    wr(5'h00, 32'd7);
    idle(2);
    wr(5'h10, 32'd1);
    rd_check(5'h10, 32'd1, "match_set_wins");
    check("match_irq", {31'd0, irq}, 32'h1);
    wr(5'h10, 32'd1);
    rd_check(5'h10, 32'd0, "w1c_clear");
    check("w1c_irq_drop", {31'd0, irq}, 32'h0);
    wr(5'h00, 32'd0);

    // Decode
    drive(BASE + 32'h20, 1'b1, 32'hDEAD_BEEF);
    #1 check("decode_out_hit", {31'd0, hit}, 32'h0);
    check("decode_out_rdata", memreaddata, 32'h0);
    drive(BASE + 32'h14, 1'b1, 32'hDEAD_BEEF);
    #1 check("decode_14_hit", {31'd0, hit}, 32'h1);
    check("decode_14_rdata", memreaddata, 32'h0);
    drive(BASE + 32'h0B, 1'b0, 32'h0);
    #1 check("decode_0b", memreaddata, 32'd100);
    drive(32'h1234_0008, 1'b0, 32'h0);
    #1 check("decode_miss_rdata", memreaddata, 32'h0);
    rd_check(5'h08, 32'd100, "decode_compare_kept");
    rd_check(5'h00, 32'd0, "decode_ctrl_kept");

    // Randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        drive(BASE, 1'b0, 32'h0);
        reset = 1'b1;
        drive(BASE, 1'b0, 32'h0);
        reset = 1'b0;
      end
      w  = 3'($urandom_range(0, 7));
      a  = BASE + {27'd0, w, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 19) == 0) a = $urandom;
      we = ($urandom_range(0, 9) < 3);
      case (w)
        3'd1:    d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
        3'd2:    d = 32'($urandom_range(0, 12));
        3'd3:    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      drive(a, we, d);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
